// File: rtl/instr_type.sv
// ---------------------------------------------------------------------------
// instr_type
// Shared instruction-type definitions for the branch path.
//   branch_kind_t   : decoded branch kind produced by decode_branch.
//   branch_result_t : resolved branch, captured whole into the skid buffer.
//   RESULT_XLEN     : datapath width of the result struct.
//   PC_STEP         : distance from a branch PC to its fall-through PC.
// ---------------------------------------------------------------------------
package instr_type;

    localparam int RESULT_XLEN = 32;

    typedef enum logic [2:0] {
        bk_invalid = 3'd0,
        bk_beq     = 3'd1,
        bk_bne     = 3'd2,
        bk_blt     = 3'd3,
        bk_bge     = 3'd4,
        bk_bltu    = 3'd5,
        bk_bgeu    = 3'd6
    } branch_kind_t;

    typedef struct packed {
        logic                   taken;
        logic [RESULT_XLEN-1:0] target;
        logic [RESULT_XLEN-1:0] next_pc;
        logic                   misaligned;
        logic                   illegal;
    } branch_result_t;

    localparam logic [RESULT_XLEN-1:0] PC_STEP = RESULT_XLEN'(4);

endpackage

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Purely combinational RV32I branch-condition evaluator.
//   kind_i    : decoded branch kind
//   rs1_i     : first source operand
//   rs2_i     : second source operand
//   taken_o   : condition holds for this kind
//   illegal_o : kind is bk_invalid or an encoding with no branch meaning
// ---------------------------------------------------------------------------
module branch_cmp
    import instr_type::*;
#(
    parameter int XLEN = 32
) (
    input  branch_kind_t    kind_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o,
    output logic            illegal_o
);

    // Unknown encodings fall into default so they can never be taken.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (kind_i)
            bk_beq:  taken_o = (rs1_i == rs2_i);
            bk_bne:  taken_o = (rs1_i != rs2_i);
            bk_blt:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            bk_bge:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            bk_bltu: taken_o = (rs1_i <  rs2_i);
            bk_bgeu: taken_o = (rs1_i >= rs2_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Resolves a decoded branch (taken, target, next PC, exception flags) and
// holds the registered result in a 2-entry skid buffer.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake (in_ready is registered)
//   in_kind, in_pc, in_imm, in_rs1, in_rs2 : branch to resolve
//   flush           : kills held and incoming entries
//   out_valid/ready : downstream handshake
//   out_taken, out_target, out_next_pc, out_misaligned, out_illegal : result
// The result struct width is set by instr_type::RESULT_XLEN; XLEN must match.
// ---------------------------------------------------------------------------
module branch_resolve
    import instr_type::*;
#(
    parameter int XLEN = RESULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  branch_kind_t    in_kind,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_misaligned,
    output logic            out_illegal
);

    logic           cmpTaken;
    logic           cmpIllegal;
    logic [XLEN-1:0] targetSum;
    logic [XLEN-1:0] fallThrough;
    branch_result_t newResult;

    branch_result_t mEntry_q, mEntry_d;
    branch_result_t sEntry_q, sEntry_d;
    logic           mValid_q, mValid_d;
    logic           sValid_q, sValid_d;
    logic           inReady_q, inReady_d;

    logic           accept;
    logic           drain;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .kind_i    (in_kind),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .taken_o   (cmpTaken),
        .illegal_o (cmpIllegal)
    );

    // Both adders wrap at XLEN bits; the target is produced even when the
    // branch falls through so downstream can always observe it.
    always_comb begin
        targetSum             = in_pc + in_imm;
        fallThrough           = in_pc + PC_STEP;
        newResult             = '0;
        newResult.taken       = cmpTaken;
        newResult.target      = targetSum;
        newResult.next_pc     = cmpTaken ? targetSum : fallThrough;
        newResult.misaligned  = cmpTaken && (targetSum[1:0] != 2'b00);
        newResult.illegal     = cmpIllegal;
    end

    // Skid buffer next state. M always drives the outputs; S only fills when
    // an accept lands while M is stalled, and refills M when M drains. S is
    // never full while in_ready is high, so accept and S->M cannot collide.
    always_comb begin
        accept    = in_valid && inReady_q;
        drain     = mValid_q && out_ready;
        mEntry_d  = mEntry_q;
        sEntry_d  = sEntry_q;
        mValid_d  = mValid_q;
        sValid_d  = sValid_q;
        if (flush) begin
            mEntry_d = '0;
            sEntry_d = '0;
            mValid_d = 1'b0;
            sValid_d = 1'b0;
        end else if (!mValid_q) begin
            if (accept) begin
                mEntry_d = newResult;
                mValid_d = 1'b1;
            end
        end else if (drain) begin
            if (sValid_q) begin
                mEntry_d = sEntry_q;
                sValid_d = 1'b0;
            end else if (accept) begin
                mEntry_d = newResult;
            end else begin
                mValid_d = 1'b0;
            end
        end else if (accept) begin
            sEntry_d = newResult;
            sValid_d = 1'b1;
        end
        inReady_d = !sValid_d;
    end

    // State registers; reset drops every held entry and blocks upstream
    // for the reset cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            mEntry_q  <= '0;
            sEntry_q  <= '0;
            mValid_q  <= 1'b0;
            sValid_q  <= 1'b0;
            inReady_q <= 1'b0;
        end else begin
            mEntry_q  <= mEntry_d;
            sEntry_q  <= sEntry_d;
            mValid_q  <= mValid_d;
            sValid_q  <= sValid_d;
            inReady_q <= inReady_d;
        end
    end

    assign in_ready       = inReady_q;
    assign out_valid      = mValid_q;
    assign out_taken      = mEntry_q.taken;
    assign out_target     = mEntry_q.target;
    assign out_next_pc    = mEntry_q.next_pc;
    assign out_misaligned = mEntry_q.misaligned;
    assign out_illegal    = mEntry_q.illegal;

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based reference model of the branch stage.
// ---------------------------------------------------------------------------
module tb_branch_resolve;
    import instr_type::*;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] nextPc;
        logic        misaligned;
        logic        illegal;
    } expRes_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    branch_kind_t in_kind;
    logic [31:0]  in_pc;
    logic [31:0]  in_imm;
    logic [31:0]  in_rs1;
    logic [31:0]  in_rs2;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic         out_taken;
    logic [31:0]  out_target;
    logic [31:0]  out_next_pc;
    logic         out_misaligned;
    logic         out_illegal;

    int      testCount = 0;
    int      failCount = 0;
    expRes_t expQ[$];
    logic    readyExp  = 1'b0;
    logic    zeroExp   = 1'b1;

    branch_resolve #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kind        (in_kind),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_next_pc    (out_next_pc),
        .out_misaligned (out_misaligned),
        .out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // What a branch should resolve to, straight from the RV32I rules.
    function automatic expRes_t refModel(input logic [2:0] kind, input logic [31:0] pc,
                                         input logic [31:0] imm, input logic [31:0] rs1,
                                         input logic [31:0] rs2);
        expRes_t r;
        int      s1;
        int      s2;
        s1 = int'(rs1);
        s2 = int'(rs2);
        r.illegal = 1'b0;
        case (kind)
            3'd1:    r.taken = (rs1 == rs2);
            3'd2:    r.taken = (rs1 != rs2);
            3'd3:    r.taken = (s1 < s2);
            3'd4:    r.taken = (s1 >= s2);
            3'd5:    r.taken = (rs1 < rs2);
            3'd6:    r.taken = (rs1 >= rs2);
            default: begin
                r.taken   = 1'b0;
                r.illegal = 1'b1;
            end
        endcase
        r.target     = pc + imm;
        r.nextPc     = r.taken ? r.target : pc + 32'd4;
        r.misaligned = r.taken && (r.target % 4 != 0);
        return r;
    endfunction

    // One clock: check outputs mid-cycle, advance the model with the inputs
    // that will be sampled at the coming edge, then move past the edge.
    task automatic runCycle();
        expRes_t h;
        logic    popped;
        @(negedge clk);
        checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
        checkOutput("in_ready", 32'(in_ready), 32'(readyExp));
        if (expQ.size() > 0) begin
            h = expQ[0];
            checkOutput("out_taken", 32'(out_taken), 32'(h.taken));
            checkOutput("out_target", out_target, h.target);
            checkOutput("out_next_pc", out_next_pc, h.nextPc);
            checkOutput("out_misaligned", 32'(out_misaligned), 32'(h.misaligned));
            checkOutput("out_illegal", 32'(out_illegal), 32'(h.illegal));
        end else if (zeroExp) begin
            checkOutput("idle_payload",
                        {29'd0, out_taken, out_misaligned, out_illegal} | out_target | out_next_pc,
                        32'd0);
        end
        if (rst) begin
            expQ.delete();
            readyExp = 1'b0;
            zeroExp  = 1'b1;
        end else begin
            popped = (expQ.size() > 0) && out_ready;
            if (flush) begin
                expQ.delete();
                readyExp = 1'b1;
                zeroExp  = 1'b0;
            end else begin
                if (popped) void'(expQ.pop_front());
                if (in_valid && readyExp) begin
                    expQ.push_back(refModel(in_kind, in_pc, in_imm, in_rs1, in_rs2));
                    zeroExp = 1'b0;
                end
                readyExp = (expQ.size() < 2);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] kind, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic valid,
                                 input logic outRdy, input logic fl);
        in_kind   = branch_kind_t'(kind);
        in_pc     = pc;
        in_imm    = imm;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_valid  = valid;
        out_ready = outRdy;
        flush     = fl;
        runCycle();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

        applyStimulus(3'd1, 32'h100, 32'h20, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0);
        checkOutput("beq_taken", 32'(out_taken), 32'd1);
        checkOutput("beq_target", out_target, 32'h120);
        checkOutput("beq_next_pc", out_next_pc, 32'h120);

        applyStimulus(3'd3, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0);
        checkOutput("blt_taken", 32'(out_taken), 32'd1);
        applyStimulus(3'd5, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0);
        checkOutput("bltu_taken", 32'(out_taken), 32'd0);
        checkOutput("bltu_next_pc", out_next_pc, 32'h204);

        applyStimulus(3'd0, 32'h300, 32'h8, 32'h1, 32'h1, 1'b1, 1'b1, 1'b0);
        checkOutput("invalid_illegal", 32'(out_illegal), 32'd1);
        checkOutput("invalid_taken", 32'(out_taken), 32'd0);
        applyStimulus(3'd2, 32'h100, 32'h12, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
        checkOutput("bne_misaligned", 32'(out_misaligned), 32'd1);
        checkOutput("bne_target", out_target, 32'h112);
        checkOutput("bne_next_pc", out_next_pc, 32'h112);
        applyStimulus(3'd7, 32'h400, 32'h8, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0);
        checkOutput("unlisted_illegal", 32'(out_illegal), 32'd1);
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Stall: three offered, two accepted, then release and drain in order.
        for (int i = 0; i < 3; i++)
            applyStimulus(3'd1, 32'h1000 + 32'(i * 16), 32'h40, 32'h7, 32'h7, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_head_next_pc", out_next_pc, 32'h1040);
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("release_second_next_pc", out_next_pc, 32'h1050);
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Flush with both entries held and a new branch offered.
        for (int i = 0; i < 2; i++)
            applyStimulus(3'd2, 32'h2000 + 32'(i * 4), 32'h10, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'd2, 32'h2100, 32'h10, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // PC wrap on fall-through, then reset with that entry still held.
        applyStimulus(3'd6, 32'hFFFF_FFFC, 32'h8, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
        checkOutput("wrap_next_pc", out_next_pc, 32'h0);
        checkOutput("wrap_taken", 32'(out_taken), 32'd0);
        rst = 1'b1;
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_target", out_target, 32'd0);
        checkOutput("midreset_next_pc", out_next_pc, 32'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom & 32'hFFFF_FFFE, a, b,
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 39) == 0));
        end
        rst = 1'b0;
        applyStimulus(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
